// File: rtl/conversor_resultado_ascii.sv
// Signed 16-bit to ASCII decimal formatter: double-dabble conversion, one bit per clock,
// followed by a formatting step that presents a sign character plus five held digits.
module conversor_resultado_ascii #(
  parameter bit SUPRIMIR_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] valor,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sinal_ascii,
  output logic [39:0] digitos_ascii,
  output logic [1:0]  o_estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FORMATA  = 2'd2
  } estado_t;

  localparam logic [39:0] DIGITOS_RESET = SUPRIMIR_ZEROS ? 40'h2020202030 : 40'h3030303030;

  estado_t     r_estado;
  logic        r_negativo;
  logic [15:0] r_mag;
  logic [19:0] r_bcd;
  logic [3:0]  r_cont;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_sinal;
  logic [39:0] r_digitos;

  logic [19:0] w_bcd_adj;
  logic [39:0] w_digitos;
  logic        w_zeros_acima;
  logic [3:0]  w_nib;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Leading zeros above the units digit become spaces until the first nonzero nibble.
  always_comb begin
    w_digitos     = '0;
    w_zeros_acima = SUPRIMIR_ZEROS;
    w_nib         = '0;
    for (int i = 4; i >= 1; i--) begin
      w_nib = r_bcd[4*i +: 4];
      if (w_zeros_acima && (w_nib == 4'd0)) begin
        w_digitos[8*i +: 8] = 8'h20;
      end else begin
        w_digitos[8*i +: 8] = {4'h3, w_nib};
        w_zeros_acima       = 1'b0;
      end
    end
    w_digitos[7:0] = {4'h3, r_bcd[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_negativo <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_cont     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sinal    <= 8'h20;
      r_digitos  <= DIGITOS_RESET;
    end else begin
      r_done <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (start) begin
            r_negativo <= valor[15];
            r_mag      <= valor[15] ? (~valor + 16'd1) : valor;
            r_bcd      <= '0;
            r_cont     <= '0;
            r_busy     <= 1'b1;
            r_estado   <= CONVERTE;
          end
        end
        CONVERTE: begin
          r_bcd  <= {w_bcd_adj[18:0], r_mag[15]};
          r_mag  <= {r_mag[14:0], 1'b0};
          r_cont <= r_cont + 4'd1;
          if (r_cont == 4'd15)
            r_estado <= FORMATA;
        end
        FORMATA: begin
          r_sinal   <= r_negativo ? 8'h2D : 8'h20;
          r_digitos <= w_digitos;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_estado  <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign sinal_ascii   = r_sinal;
  assign digitos_ascii = r_digitos;
  assign o_estado      = r_estado;

endmodule

// File: tb/tb_conversor_resultado_ascii.sv
// Bench for conversor_resultado_ascii: two instances (zero suppression on/off) share stimulus
// and are compared against a decimal-arithmetic reference model.
module tb_conversor_resultado_ascii;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] valor;

  logic        busy, done;
  logic [7:0]  sinal_ascii;
  logic [39:0] digitos_ascii;
  logic [1:0]  estado;

  logic        busy_nz, done_nz;
  logic [7:0]  sinal_nz;
  logic [39:0] digitos_nz;
  logic [1:0]  estado_nz;

  int checks   = 0;
  int failures = 0;

  conversor_resultado_ascii #(.SUPRIMIR_ZEROS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .valor(valor),
    .busy(busy), .done(done), .sinal_ascii(sinal_ascii),
    .digitos_ascii(digitos_ascii), .o_estado(estado)
  );

  conversor_resultado_ascii #(.SUPRIMIR_ZEROS(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .start(start), .valor(valor),
    .busy(busy_nz), .done(done_nz), .sinal_ascii(sinal_nz),
    .digitos_ascii(digitos_nz), .o_estado(estado_nz)
  );

  always #5 clk = ~clk;

  // Reference: plain decimal arithmetic on the magnitude, then text formatting.
  function automatic logic [39:0] ref_digitos(input logic [15:0] v, input bit suprimir);
    int          mag;
    int          tmp;
    int          d[5];
    bit          lead;
    logic [39:0] r;
    mag = v[15] ? (65536 - int'(v)) : int'(v);
    tmp = mag;
    for (int i = 0; i < 5; i++) begin
      d[i] = tmp % 10;
      tmp  = tmp / 10;
    end
    lead = suprimir;
    r    = '0;
    for (int i = 4; i >= 0; i--) begin
      if (lead && d[i] == 0 && i != 0) begin
        r[8*i +: 8] = 8'h20;
      end else begin
        r[8*i +: 8] = 8'(48 + d[i]);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_sinal(input logic [15:0] v);
    return v[15] ? 8'h2D : 8'h20;
  endfunction

  // Driver: caller is positioned at a negedge. Returns edges from acceptance to done
  // (capped at 40) and the number of sampled cycles with busy high.
  task automatic do_conv(input logic [15:0] v, input bit pulse_busy, input bit scramble,
                         output int edges, output int busy_cnt);
    start    = 1'b1;
    valor    = v;
    edges    = 0;
    busy_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done || edges >= 40) break;
      start = pulse_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (scramble) valor = 16'($urandom);
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    valor = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (sinal_ascii !== 8'h20) begin
      failures++;
      $display("FAIL reset_sinal: got %h required 20", sinal_ascii);
    end
    checks++;
    if (digitos_ascii !== 40'h2020202030) begin
      failures++;
      $display("FAIL reset_digitos: got %h required 2020202030", digitos_ascii);
    end
    checks++;
    if (digitos_nz !== 40'h3030303030) begin
      failures++;
      $display("FAIL reset_digitos_nz: got %h required 3030303030", digitos_nz);
    end
  endtask

  task automatic test_basic;
    int e, b;
    @(negedge clk);
    do_conv(16'd12345, 1'b0, 1'b0, e, b);
    checks++;
    if (e !== 17) begin
      failures++;
      $display("FAIL basic_latency: got %0d edges required 17", e);
    end
    checks++;
    if (b !== 17) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d required 17", b);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_at_done: got %b required 0", busy);
    end
    checks++;
    if (digitos_ascii !== 40'h3132333435 || sinal_ascii !== 8'h20) begin
      failures++;
      $display("FAIL basic_value: got %h %h required 20 3132333435", sinal_ascii, digitos_ascii);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_negative;
    int e, b;
    @(negedge clk);
    do_conv(16'hFFFF, 1'b0, 1'b0, e, b);
    checks++;
    if (e !== 17 || sinal_ascii !== 8'h2D || digitos_ascii !== 40'h2020202031) begin
      failures++;
      $display("FAIL neg_one: edges=%0d got %h %h required 17 2D 2020202031", e, sinal_ascii, digitos_ascii);
    end
    checks++;
    if (digitos_nz !== 40'h3030303031 || sinal_nz !== 8'h2D) begin
      failures++;
      $display("FAIL neg_one_nz: got %h %h required 2D 3030303031", sinal_nz, digitos_nz);
    end
  endtask

  task automatic test_back_to_back;
    int e, b;
    @(negedge clk);
    do_conv(16'h8000, 1'b0, 1'b0, e, b);
    checks++;
    if (e !== 17 || sinal_ascii !== 8'h2D || digitos_ascii !== 40'h3332373638) begin
      failures++;
      $display("FAIL min_value: edges=%0d got %h %h required 17 2D 3332373638", e, sinal_ascii, digitos_ascii);
    end
    do_conv(16'd100, 1'b0, 1'b0, e, b);
    checks++;
    if (e !== 17) begin
      failures++;
      $display("FAIL b2b_latency: got %0d edges required 17", e);
    end
    checks++;
    if (sinal_ascii !== 8'h20 || digitos_ascii !== 40'h2020313030) begin
      failures++;
      $display("FAIL b2b_value: got %h %h required 20 2020313030", sinal_ascii, digitos_ascii);
    end
    checks++;
    if (digitos_nz !== 40'h3030313030) begin
      failures++;
      $display("FAIL b2b_value_nz: got %h required 3030313030", digitos_nz);
    end
  endtask

  task automatic test_ignore_start;
    int e, b, n;
    @(negedge clk);
    do_conv(16'd7, 1'b1, 1'b1, e, b);
    checks++;
    if (e !== 17) begin
      failures++;
      $display("FAIL ignore_latency: got %0d edges required 17", e);
    end
    checks++;
    if (digitos_ascii !== 40'h2020202037 || sinal_ascii !== 8'h20) begin
      failures++;
      $display("FAIL ignore_value: got %h %h required 20 2020202037", sinal_ascii, digitos_ascii);
    end
    checks++;
    if (digitos_nz !== 40'h3030303037) begin
      failures++;
      $display("FAIL ignore_value_nz: got %h required 3030303037", digitos_nz);
    end
    count_done(25, n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL ignore_extra_done: got %0d extra pulses required 0", n);
    end
  endtask

  task automatic test_reset_mid;
    int e, b, n;
    @(negedge clk);
    start = 1'b1;
    valor = 16'hFB2E;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    valor = 16'h0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sinal_ascii !== 8'h20 || digitos_ascii !== 40'h2020202030) begin
      failures++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b got %h %h required 0 0 20 2020202030",
               busy, done, sinal_ascii, digitos_ascii);
    end
    checks++;
    if (digitos_nz !== 40'h3030303030) begin
      failures++;
      $display("FAIL rst_mid_outputs_nz: got %h required 3030303030", digitos_nz);
    end
    count_done(25, n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL rst_mid_no_done: got %0d pulses required 0", n);
    end
    do_conv(16'd500, 1'b0, 1'b0, e, b);
    checks++;
    if (e !== 17 || digitos_ascii !== 40'h2020353030 || sinal_ascii !== 8'h20) begin
      failures++;
      $display("FAIL rst_mid_recover: edges=%0d got %h %h required 17 20 2020353030", e, sinal_ascii, digitos_ascii);
    end
  endtask

  task automatic test_random;
    logic [15:0] edge_vals[8];
    logic [15:0] v;
    int e, b;
    edge_vals = '{16'd0, 16'd9, 16'd10, 16'd32767, 16'h8001, 16'd10000, 16'd9999, 16'hFFF6};
    for (int k = 0; k < 28; k++) begin
      v = (k < 8) ? edge_vals[k] : 16'($urandom);
      @(negedge clk);
      do_conv(v, 1'b0, 1'b0, e, b);
      checks++;
      if (e !== 17 || sinal_ascii !== ref_sinal(v) || digitos_ascii !== ref_digitos(v, 1'b1)) begin
        failures++;
        $display("FAIL random_value v=%h: edges=%0d got %h %h required %h %h",
                 v, e, sinal_ascii, digitos_ascii, ref_sinal(v), ref_digitos(v, 1'b1));
      end
      checks++;
      if (sinal_nz !== ref_sinal(v) || digitos_nz !== ref_digitos(v, 1'b0)) begin
        failures++;
        $display("FAIL random_value_nz v=%h: got %h %h required %h %h",
                 v, sinal_nz, digitos_nz, ref_sinal(v), ref_digitos(v, 1'b0));
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valor = 16'h0000;
    test_reset();
    test_basic();
    test_negative();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
